// File: rtl/ad4003_acq_sequencer.sv
// ad4003_acq_sequencer
//   Acquisition controller for the AD4003 deserializer read side. It finds each
//   completed conversion frame (falling edge of reader_en_sync), decides whether
//   to keep it based on arm/trigger/stop, decimation and frame-count limits, and
//   streams kept frames out as AXI4-Stream: one header beat, then one
//   sign-extended beat per channel.
//
// Ports
//   adc_read_clk, rst_n          clock, asynchronous active-low reset
//   acq_arm, acq_stop, soft_trig control pulses
//   ext_trig, trig_sel           asynchronous external trigger and its enable
//   decim                        frames skipped between accepted frames
//   n_frames                     accepted frames per run (0 = continuous)
//   clear_ovf                    clears the sticky overflow flag
//   reader_en_sync, adc_data_arr deserializer shift enable and shift registers
//   m_axis_*                     32-bit AXI4-Stream master
//   state_out, frame_cnt,
//   overflow, busy               status
module ad4003_acq_sequencer #(
  parameter int ADC_CHANNELS   = 8,
  parameter int ADC_DATA_WIDTH = 18,
  parameter int DECIM_WIDTH    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                   adc_read_clk,
  input  logic                                   rst_n,
  input  logic                                   acq_arm,
  input  logic                                   acq_stop,
  input  logic                                   soft_trig,
  input  logic                                   ext_trig,
  input  logic                                   trig_sel,
  input  logic [DECIM_WIDTH-1:0]                 decim,
  input  logic [CNT_WIDTH-1:0]                   n_frames,
  input  logic                                   clear_ovf,
  input  logic                                   reader_en_sync,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
  output logic [31:0]                            m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic [1:0]                             state_out,
  output logic [CNT_WIDTH-1:0]                   frame_cnt,
  output logic                                   overflow,
  output logic                                   busy
);

  localparam int BEAT_W = $clog2(ADC_CHANNELS + 1);
  localparam int SNAP_W = ADC_DATA_WIDTH * ADC_CHANNELS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ADC_CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic ren_q;
  logic ext_s1_q, ext_s2_q, ext_prev_q;
  logic frame_done, ext_pulse, trig;

  logic [DECIM_WIDTH-1:0] decim_cnt_q, decim_cnt_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic                   ovf_q, ovf_d;

  logic                   em_active_q, em_active_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [SNAP_W-1:0]      snap_q, snap_d;
  logic [15:0]            hdr_cnt_q, hdr_cnt_d;

  logic hs, last_hs, em_free, run_fd, eligible, accept, drop;
  logic [BEAT_W-1:0]         ch_sel;
  logic [ADC_DATA_WIDTH-1:0] ch_val;

  // Input conditioning: frame-end detect and ext_trig 2-FF sync + edge register.
  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_q      <= 1'b0;
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      ren_q      <= reader_en_sync;
      ext_s1_q   <= ext_trig;
      ext_s2_q   <= ext_s1_q;
      ext_prev_q <= ext_s2_q;
    end
  end

  assign frame_done = ren_q & ~reader_en_sync;
  assign ext_pulse  = ext_s2_q & ~ext_prev_q;
  assign trig       = soft_trig | (trig_sel & ext_pulse);

  // The emitter counts as free when idle or when its final beat handshakes
  // this cycle, so back-to-back packets need no gap.
  assign hs       = em_active_q & m_axis_tready;
  assign last_hs  = hs & (beat_q == LAST_BEAT);
  assign em_free  = ~em_active_q | last_hs;
  assign run_fd   = (state_q == S_RUN) & frame_done;
  assign eligible = run_fd & (decim_cnt_q == '0);
  assign accept   = eligible & em_free;
  assign drop     = eligible & ~em_free;

  assign frame_cnt_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + CNT_WIDTH'(1);

  // FSM state register
  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acq_arm) state_d = S_ARMED;
      S_ARMED: begin
        if (acq_stop)  state_d = S_IDLE;
        else if (trig) state_d = S_RUN;
      end
      S_RUN: begin
        // A frame ending together with acq_stop has already been handled by
        // the datapath this cycle, so stopping here loses nothing.
        if (acq_stop ||
            (accept && (n_frames != '0) && (frame_cnt_inc == n_frames)))
          state_d = S_FLUSH;
      end
      S_FLUSH: if (!em_active_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: decimation, frame counting, overflow, emitter
  always_comb begin
    decim_cnt_d = decim_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    em_active_d = em_active_q;
    beat_d      = beat_q;
    snap_d      = snap_q;
    hdr_cnt_d   = hdr_cnt_q;

    if ((state_q == S_IDLE) && acq_arm) begin
      frame_cnt_d = '0;
      decim_cnt_d = '0;
    end

    if (run_fd)
      decim_cnt_d = (decim_cnt_q != '0) ? decim_cnt_q - DECIM_WIDTH'(1) : decim;

    if (hs) begin
      if (beat_q == LAST_BEAT) em_active_d = 1'b0;
      else                     beat_d      = beat_q + BEAT_W'(1);
    end

    if (accept) begin
      em_active_d = 1'b1;
      beat_d      = '0;
      snap_d      = adc_data_arr;
      hdr_cnt_d   = frame_cnt_inc[15:0];
      frame_cnt_d = frame_cnt_inc;
    end

    if (clear_ovf) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_cnt_q <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      em_active_q <= 1'b0;
      beat_q      <= '0;
      snap_q      <= '0;
      hdr_cnt_q   <= '0;
    end else begin
      decim_cnt_q <= decim_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      em_active_q <= em_active_d;
      beat_q      <= beat_d;
      snap_q      <= snap_d;
      hdr_cnt_q   <= hdr_cnt_d;
    end
  end

  // Outputs. tdata is a pure function of registered beat/snapshot state,
  // so it holds steady under backpressure.
  always_comb begin
    ch_sel = (beat_q == '0) ? '0 : beat_q - BEAT_W'(1);
    ch_val = snap_q[int'(ch_sel) * ADC_DATA_WIDTH +: ADC_DATA_WIDTH];

    state_out     = state_q;
    frame_cnt     = frame_cnt_q;
    overflow      = ovf_q;
    busy          = (state_q != S_IDLE) | em_active_q;
    m_axis_tvalid = em_active_q;
    m_axis_tlast  = em_active_q & (beat_q == LAST_BEAT);
    m_axis_tdata  = '0;
    if (em_active_q) begin
      if (beat_q == '0)
        m_axis_tdata = {8'hA5, 8'(ADC_CHANNELS), hdr_cnt_q};
      else
        m_axis_tdata = {{(32-ADC_DATA_WIDTH){ch_val[ADC_DATA_WIDTH-1]}}, ch_val};
    end
  end

endmodule

// File: tb/tb_ad4003_acq_sequencer.sv
`timescale 1ns/1ps
module tb_ad4003_acq_sequencer;

  localparam int NCH  = 8;
  localparam int DW   = 18;
  localparam int DECW = 16;
  localparam int CW   = 32;
  localparam int SW   = NCH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          acq_arm = 1'b0, acq_stop = 1'b0, soft_trig = 1'b0;
  logic          ext_trig = 1'b0, trig_sel = 1'b0, clear_ovf = 1'b0;
  logic [DECW-1:0] decim = '0;
  logic [CW-1:0]   n_frames = '0;
  logic          reader_en_sync = 1'b0;
  logic [SW-1:0] adc_data_arr = '0;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [1:0]    state_out;
  logic [CW-1:0] frame_cnt;
  logic          overflow, busy;

  always #5 clk = ~clk;

  ad4003_acq_sequencer #(
    .ADC_CHANNELS(NCH), .ADC_DATA_WIDTH(DW), .DECIM_WIDTH(DECW), .CNT_WIDTH(CW)
  ) dut (
    .adc_read_clk(clk), .rst_n(rst_n), .acq_arm(acq_arm), .acq_stop(acq_stop),
    .soft_trig(soft_trig), .ext_trig(ext_trig), .trig_sel(trig_sel),
    .decim(decim), .n_frames(n_frames), .clear_ovf(clear_ovf),
    .reader_en_sync(reader_en_sync), .adc_data_arr(adc_data_arr),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .state_out(state_out), .frame_cnt(frame_cnt), .overflow(overflow), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packet contents are queued whole at acceptance; the stream is "busy"
  // exactly while that queue is non-empty.
  int            m_state;
  logic [CW-1:0] m_cnt;
  int            m_dec;
  logic          m_ovf;
  logic          m_ren;
  logic [2:0]    m_h;
  logic [32:0]   exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cnt = '0; m_dec = 0; m_ovf = 1'b0; m_ren = 1'b0; m_h = '0;
      exp_q.delete();
    end else begin : step
      bit fd, xp, trg, hsk, free, empty_pre, ovf_set;
      int nst;
      fd        = m_ren && !reader_en_sync;
      xp        = m_h[1] && !m_h[2];
      trg       = soft_trig || (trig_sel && xp);
      empty_pre = (exp_q.size() == 0);
      hsk       = !empty_pre && m_axis_tready;
      free      = empty_pre || (exp_q.size() == 1 && hsk);
      if (hsk) void'(exp_q.pop_front());
      ovf_set = 0;
      nst = m_state;
      case (m_state)
        0: if (acq_arm) begin nst = 1; m_cnt = '0; m_dec = 0; end
        1: if (acq_stop) nst = 0; else if (trg) nst = 2;
        2: begin
          if (fd) begin
            if (m_dec > 0) m_dec = m_dec - 1;
            else begin
              m_dec = int'(decim);
              if (free) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                exp_q.push_back({1'b0, 8'hA5, 8'(NCH), m_cnt[15:0]});
                for (int k = 0; k < NCH; k++) begin
                  int v;
                  v = int'(adc_data_arr[k*DW +: DW]);
                  if (v >= 131072) v = v - 262144;
                  exp_q.push_back({(k == NCH-1), 32'(v)});
                end
                if (n_frames != 0 && m_cnt == n_frames) nst = 3;
              end else ovf_set = 1;
            end
          end
          if (acq_stop) nst = 3;
        end
        default: if (empty_pre) nst = 0;
      endcase
      m_state = nst;
      if (clear_ovf) m_ovf = 1'b0;
      if (ovf_set)   m_ovf = 1'b1;
      m_h   = {m_h[1:0], ext_trig};
      m_ren = reader_en_sync;
    end
  end

  // ---------------- compare / capture ----------------
  logic [32:0] got_q[$];
  int          st_log[$];
  int          last_st = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("state_out", 32'(state_out), 32'(m_state));
      check("frame_cnt", frame_cnt, m_cnt);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_state != 0 || exp_q.size() != 0));
      check("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("tdata", m_axis_tdata, exp_q[0][31:0]);
        check("tlast", 32'(m_axis_tlast), 32'(exp_q[0][32]));
      end
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
      if (int'(state_out) != last_st) begin
        last_st = int'(state_out);
        st_log.push_back(last_st);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [SW-1:0] d);
    adc_data_arr   = d;
    reader_en_sync = 1'b1;
    tick(18);
    reader_en_sync = 1'b0;
    tick(22);
  endtask

  task automatic arm_and_trig();
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    soft_trig = 1'b1; tick(); soft_trig = 1'b0;
  endtask

  function automatic logic [SW-1:0] pat(input int base, input int step);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = DW'(base + k*step);
    return r;
  endfunction

  function automatic logic [32:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 33'h1_DEAD_BEEF;
  endfunction

  initial begin
    tick(3);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: three frames, no decimation, stop at n_frames
    decim = 16'd0; n_frames = 32'd3; got_q.delete();
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check("t1_armed", 32'(state_out), 32'd1);
    soft_trig = 1'b1; tick(); soft_trig = 1'b0;
    check("t1_run", 32'(state_out), 32'd2);
    repeat (3) send_frame(pat(18'h3FFFF, -1));
    check("t1_beats", 32'(got_q.size()), 32'd27);
    check("t1_hdr1", got_at(0)[31:0], 32'hA508_0001);
    check("t1_hdr2", got_at(9)[31:0], 32'hA508_0002);
    check("t1_hdr3", got_at(18)[31:0], 32'hA508_0003);
    check("t1_ch0", got_at(1)[31:0], 32'hFFFF_FFFF);
    check("t1_ch1", got_at(2)[31:0], 32'hFFFF_FFFE);
    check("t1_last8", 32'(got_at(8)[32]), 32'd1);
    check("t1_last7", 32'(got_at(7)[32]), 32'd0);
    check("t1_idle", 32'(state_out), 32'd0);
    check("t1_cnt", frame_cnt, 32'd3);

    // 2: decimation by 3 with n_frames=2
    decim = 16'd2; n_frames = 32'd2; got_q.delete();
    arm_and_trig();
    tick();
    st_log.delete();
    for (int i = 1; i <= 6; i++) send_frame(pat(i, 4096));
    check("t2_beats", 32'(got_q.size()), 32'd18);
    check("t2_ch0a", got_at(1)[31:0], 32'd1);
    check("t2_ch0b", got_at(10)[31:0], 32'd4);
    check("t2_ch1b", got_at(11)[31:0], 32'h0000_1004);
    check("t2_hdr2", got_at(9)[31:0], 32'hA508_0002);
    check("t2_nst", 32'(st_log.size()), 32'd2);
    check("t2_st0", (st_log.size() > 0) ? 32'(st_log[0]) : 32'hFF, 32'd3);
    check("t2_st1", (st_log.size() > 1) ? 32'(st_log[1]) : 32'hFF, 32'd0);
    check("t2_cnt", frame_cnt, 32'd2);

    // 3: backpressure, overflow, recovery
    decim = 16'd0; n_frames = 32'd0; got_q.delete();
    arm_and_trig();
    m_axis_tready = 1'b0;
    send_frame(pat(100, 1));
    send_frame(pat(200, 1));
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_cnt", frame_cnt, 32'd1);
    check("t3_noh", 32'(got_q.size()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("t3_hold_valid", 32'(m_axis_tvalid), 32'd1);
      check("t3_hold_data", m_axis_tdata, 32'hA508_0001);
      tick();
    end
    m_axis_tready = 1'b1;
    send_frame(pat(300, 1));
    check("t3_beats", 32'(got_q.size()), 32'd18);
    check("t3_hdr1", got_at(0)[31:0], 32'hA508_0001);
    check("t3_ch0a", got_at(1)[31:0], 32'd100);
    check("t3_hdr2", got_at(9)[31:0], 32'hA508_0002);
    check("t3_ch0b", got_at(10)[31:0], 32'd300);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    acq_stop = 1'b1; tick(); acq_stop = 1'b0;
    tick(2);
    check("t3_idle", 32'(state_out), 32'd0);

    // 4: external trigger latency and enable
    trig_sel = 1'b1;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    tick(3);
    ext_trig = 1'b1;
    tick(); check("t4_lat1", 32'(state_out), 32'd1);
    tick(); check("t4_lat2", 32'(state_out), 32'd1);
    tick(); check("t4_lat3", 32'(state_out), 32'd2);
    acq_stop = 1'b1; tick(); acq_stop = 1'b0; ext_trig = 1'b0;
    tick(3);
    check("t4_idle", 32'(state_out), 32'd0);
    trig_sel = 1'b0;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    tick(4);
    ext_trig = 1'b1;
    tick(6);
    check("t4_masked", 32'(state_out), 32'd1);
    acq_stop = 1'b1; tick(); acq_stop = 1'b0; ext_trig = 1'b0;
    tick(2);
    check("t4_idle2", 32'(state_out), 32'd0);

    // 5: stop beats trigger in ARMED; stop mid-packet in RUN
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    acq_stop = 1'b1; soft_trig = 1'b1; tick(); acq_stop = 1'b0; soft_trig = 1'b0;
    check("t5_stopwin", 32'(state_out), 32'd0);
    got_q.delete();
    send_frame(pat(5, 1));
    check("t5_nopkt", 32'(got_q.size()), 32'd0);
    arm_and_trig();
    tick();
    adc_data_arr = pat(7, 1);
    reader_en_sync = 1'b1; tick(18); reader_en_sync = 1'b0;
    tick(3);
    acq_stop = 1'b1; tick(); acq_stop = 1'b0;
    check("t5_flush", 32'(state_out), 32'd3);
    check("t5_flush_valid", 32'(m_axis_tvalid), 32'd1);
    tick(15);
    check("t5_idle", 32'(state_out), 32'd0);
    check("t5_beats", 32'(got_q.size()), 32'd9);
    check("t5_hdr", got_at(0)[31:0], 32'hA508_0001);
    check("t5_ch0", got_at(1)[31:0], 32'd7);
    check("t5_last", 32'(got_at(8)[32]), 32'd1);

    // 6: asynchronous reset mid-packet
    n_frames = 32'd0;
    m_axis_tready = 1'b0;
    arm_and_trig();
    send_frame(pat(9, 1));
    send_frame(pat(10, 1));
    check("t6_pre_valid", 32'(m_axis_tvalid), 32'd1);
    check("t6_pre_ovf", 32'(overflow), 32'd1);
    check("t6_pre_cnt", frame_cnt, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_cnt", frame_cnt, 32'd0);
    check("t6_rst_state", 32'(state_out), 32'd0);
    tick(2);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    tick(2);
    got_q.delete();
    n_frames = 32'd1;
    arm_and_trig();
    send_frame(pat(11, 1));
    check("t6_beats", 32'(got_q.size()), 32'd9);
    check("t6_hdr", got_at(0)[31:0], 32'hA508_0001);
    check("t6_idle", 32'(state_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad4003_acq_sequencer.md
Name: ad4003_acq_sequencer

Overview:
- Acquisition controller in the `adc_read_clk` domain, downstream of the AD4003 deserializer.
- Detects each completed conversion frame from the deserializer's `reader_en_sync` strobe and snapshots `adc_data_arr`.
- Gates capture by arm, trigger, stop and frame-count commands, with optional decimation.
- Serialises accepted frames onto a 32-bit AXI4-Stream: one header beat, then one beat per channel.

Parameters:
- ADC_CHANNELS, 8, channel count (even, max 48); must match the deserializer.
- ADC_DATA_WIDTH, 18, sample width; fixed.
- DECIM_WIDTH, 16, width of the decimation setting.
- CNT_WIDTH, 32, width of the frame-count limit and frame counter.

Ports:
- adc_read_clk  in  1  sole clock, same clock as the deserializer read side
- rst_n  in  1  asynchronous, active-low reset
- acq_arm  in  1  pulse; IDLE -> ARMED
- acq_stop  in  1  pulse; ends acquisition
- soft_trig  in  1  pulse; software trigger
- ext_trig  in  1  asynchronous external trigger, rising edge active
- trig_sel  in  1  1 = ext_trig enabled as a trigger source
- decim  in  DECIM_WIDTH  frames skipped between accepted frames; 0 = accept all
- n_frames  in  CNT_WIDTH  accepted frames per run; 0 = continuous
- clear_ovf  in  1  pulse; clears overflow
- reader_en_sync  in  1  deserializer shift-enable, high for 18 cycles per frame
- adc_data_arr  in  ADC_DATA_WIDTH*ADC_CHANNELS  deserializer shift registers, channel k at bits [18k +: 18]
- m_axis_tdata  out  32  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  asserted on the last channel beat of a frame
- state_out  out  2  IDLE=0, ARMED=1, RUN=2, FLUSH=3
- frame_cnt  out  CNT_WIDTH  frames accepted in the current run
- overflow  out  1  sticky; an accepted frame was dropped
- busy  out  1  state != IDLE or emitter active

Behaviour:
- Reset:
  - state = IDLE; all outputs = 0.
  - Trigger synchroniser, decimation counter and emitter are cleared.
  - Reset during an active frame drops tvalid immediately. This is the only permitted AXI-S abort.
- frame_done:
  - Condition: `reader_en_sync` was 1 in the previous cycle and is 0 now.
  - On that cycle `adc_data_arr` is stable and is snapshotted if the frame is accepted.
- ext_trig:
  - Passed through a 2-FF synchroniser plus an edge register.
  - The rising-edge pulse appears 3 cycles after the pin edge.
  - The pulse is ignored when `trig_sel` = 0.
- IDLE:
  - `acq_arm` -> ARMED; clears `frame_cnt`; loads decim_cnt = 0.
  - `acq_arm` in any other state is ignored.
- ARMED:
  - Trigger (`soft_trig` or enabled ext edge) -> RUN.
  - `acq_stop` -> IDLE; stop wins over a simultaneous trigger.
- RUN, on each frame_done:
  - If decim_cnt != 0: decrement decim_cnt; frame skipped.
  - Otherwise the frame is eligible and decim_cnt reloads from `decim`.
  - Eligible frame with emitter idle: snapshot loaded, `frame_cnt` += 1.
  - Eligible frame with emitter busy: frame dropped, `overflow` set, `frame_cnt` unchanged.
  - First frame_done after entering RUN is the first decimation candidate; frames in flight at the trigger are not discarded.
- RUN exits:
  - `n_frames` != 0 and `frame_cnt` reaches `n_frames` (on the accepting cycle) -> FLUSH.
  - `acq_stop` -> FLUSH. If it coincides with frame_done, that frame is processed first.
  - Triggers in RUN are ignored.
- FLUSH: -> IDLE on the cycle after the emitter returns to idle (`tlast` handshake complete).
- Emitter:
  - Beat 0 (header) = {8'hA5, 8'(ADC_CHANNELS), `frame_cnt`[15:0] after increment}.
  - Beats 1..N = channel 0..N-1, 18-bit two's complement sign-extended to 32 bits.
  - `tlast` on beat N.
  - `tvalid` rises the cycle after the snapshot load.
  - `tdata`/`tlast` are held stable while tvalid=1 and tready=0.
  - A beat advances only on tvalid & tready.
  - Emitter idle = no beat pending. A new snapshot may load in the same cycle as the final handshake.
  - With tready=1 a frame takes N+1 cycles, which is less than the 40-cycle frame period, so no overflow occurs under no backpressure.
- overflow:
  - `clear_ovf` clears it.
  - A set on the same cycle as `clear_ovf` wins.
  - Not cleared by `acq_arm`.
- frame_cnt: saturates at all-ones in continuous mode.

Test Plan:
1. arm, `soft_trig`, decim=0, n_frames=3, tready=1, 8 channels, ch k = 0x3FFFF-k:
   - 3 packets of 9 beats; headers 0xA5080001..0xA5080003.
   - ch0 = 0xFFFFFFFF, ch1 = 0xFFFFFFFE.
   - tlast on beat 9; returns to IDLE; frame_cnt=3.
2. decim=2, n_frames=2, frames carrying ch0 values 1..6:
   - Packets carry ch0 = 1 and 4 only.
   - state_out goes 2->3->0.
3. tready held 0 for 100 cycles during the first packet:
   - tdata stable throughout; overflow=1 after the next eligible frame.
   - On release the packet completes; header of the next packet = 0xA5080002.
4. trig_sel=1, ext_trig rising edge:
   - RUN entered 3 cycles later; with trig_sel=0 the same edge leaves state ARMED.
5. `acq_stop` and `soft_trig` in the same ARMED cycle:
   - -> IDLE, no packets.
   - `acq_stop` mid-packet in RUN -> FLUSH; the packet completes with tlast, then IDLE.
6. rst_n low mid-packet:
   - tvalid, overflow, frame_cnt, state_out all 0 asynchronously.
   - After release, a new arm/trigger yields header 0xA5080001.
